// File: rtl/key_digit_buffer.sv
// Keypad digit entry buffer: edge-detects key presses and builds a BCD entry of up to DIGITS
// digits, with clear, backspace and enter keys. All outputs are registered.
module key_digit_buffer #(
  parameter int unsigned DIGITS     = 4,
  parameter logic [3:0]  CODE_CLEAR = 4'hA,
  parameter logic [3:0]  CODE_BACK  = 4'hB,
  parameter logic [3:0]  CODE_ENTER = 4'hE
) (
  input  logic                        clkot,
  input  logic                        rst_n,
  input  logic                        key_valid,
  input  logic [3:0]                  key_code,
  output logic [4*DIGITS-1:0]         buf_digits,
  output logic [$clog2(DIGITS+1)-1:0] digit_cnt,
  output logic                        buf_full,
  output logic                        busy,
  output logic                        entry_done,
  output logic                        key_err
);

  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] FullCnt = CW'(DIGITS);

  typedef enum logic [1:0] {StIdle, StEntry, StDone} state_e;

  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] buf_d;
  logic [CW-1:0]       cnt_d;
  logic                done_d, err_d;
  logic                key_valid_q;
  logic                press;
  logic                is_digit;

  assign press    = key_valid & ~key_valid_q;
  assign is_digit = (key_code <= 4'd9);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_digits;
    cnt_d   = digit_cnt;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (press) begin
      if (key_code == CODE_CLEAR) begin
        buf_d   = '0;
        cnt_d   = '0;
        state_d = StIdle;
      end else if (is_digit) begin
        if (state_q == StDone) begin
          // A new digit after a completed entry starts a fresh entry.
          buf_d      = '0;
          buf_d[3:0] = key_code;
          cnt_d      = CW'(1);
          state_d    = StEntry;
        end else if (digit_cnt < FullCnt) begin
          buf_d   = {buf_digits[4*DIGITS-5:0], key_code};
          cnt_d   = digit_cnt + CW'(1);
          state_d = StEntry;
        end else begin
          err_d = 1'b1;
        end
      end else if (key_code == CODE_BACK) begin
        if (state_q == StEntry && digit_cnt != '0) begin
          buf_d = {4'h0, buf_digits[4*DIGITS-1:4]};
          cnt_d = digit_cnt - CW'(1);
          if (digit_cnt == CW'(1)) state_d = StIdle;
        end else begin
          err_d = 1'b1;
        end
      end else if (key_code == CODE_ENTER) begin
        if (state_q == StEntry) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clkot or negedge rst_n) begin
    if (!rst_n) begin
      // Reset high so a key held through reset release is not seen as a press.
      key_valid_q <= 1'b1;
      state_q     <= StIdle;
      buf_digits  <= '0;
      digit_cnt   <= '0;
      buf_full    <= 1'b0;
      busy        <= 1'b0;
      entry_done  <= 1'b0;
      key_err     <= 1'b0;
    end else begin
      key_valid_q <= key_valid;
      state_q     <= state_d;
      buf_digits  <= buf_d;
      digit_cnt   <= cnt_d;
      buf_full    <= (cnt_d == FullCnt);
      busy        <= (state_d == StEntry);
      entry_done  <= done_d;
      key_err     <= err_d;
    end
  end

endmodule

// File: tb/tb_key_digit_buffer.sv
// Directed self-checking bench for key_digit_buffer with DIGITS=4.
module tb_key_digit_buffer;

  logic        clkot;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] buf_digits;
  logic [2:0]  digit_cnt;
  logic        buf_full;
  logic        busy;
  logic        entry_done;
  logic        key_err;

  int n_checks = 0;
  int n_errors = 0;

  key_digit_buffer #(.DIGITS(4)) dut (
    .clkot      (clkot),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .buf_digits (buf_digits),
    .digit_cnt  (digit_cnt),
    .buf_full   (buf_full),
    .busy       (busy),
    .entry_done (entry_done),
    .key_err    (key_err)
  );

  initial clkot = 1'b0;
  always #5 clkot = ~clkot;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [15:0] b, input logic [2:0] c,
                           input logic full, input logic bsy);
    chk({tag, " buf"}, 32'(buf_digits), 32'(b));
    chk({tag, " cnt"}, 32'(digit_cnt), 32'(c));
    chk({tag, " full"}, 32'(buf_full), 32'(full));
    chk({tag, " busy"}, 32'(busy), 32'(bsy));
  endtask

  // One-cycle press then release; checks the pulses in the cycle after the press and
  // that they are gone one cycle later.
  task automatic press(input string tag, input logic [3:0] code, input logic exp_err,
                       input logic exp_done);
    @(negedge clkot);
    key_valid = 1'b1;
    key_code  = code;
    @(posedge clkot);
    #1;
    chk({tag, " err"}, 32'(key_err), 32'(exp_err));
    chk({tag, " done"}, 32'(entry_done), 32'(exp_done));
    @(negedge clkot);
    key_valid = 1'b0;
    @(posedge clkot);
    #1;
    chk({tag, " err_clr"}, 32'(key_err), 32'(0));
    chk({tag, " done_clr"}, 32'(entry_done), 32'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    repeat (2) @(posedge clkot);
    #1;
    chk_state("reset", 16'h0000, 3'd0, 1'b0, 1'b0);
    chk("reset err", 32'(key_err), 32'(0));
    chk("reset done", 32'(entry_done), 32'(0));
    @(negedge clkot);
    rst_n = 1'b1;
    @(posedge clkot);

    // 1,2,3 then ENTER
    press("d1", 4'h1, 1'b0, 1'b0);
    chk_state("after 1", 16'h0001, 3'd1, 1'b0, 1'b1);
    press("d2", 4'h2, 1'b0, 1'b0);
    press("d3", 4'h3, 1'b0, 1'b0);
    chk_state("after 123", 16'h0123, 3'd3, 1'b0, 1'b1);
    press("enter", 4'hE, 1'b0, 1'b1);
    chk_state("done 123", 16'h0123, 3'd3, 1'b0, 1'b0);

    // Digit in DONE restarts entry, then CLEAR
    press("d7 in done", 4'h7, 1'b0, 1'b0);
    chk_state("restart 7", 16'h0007, 3'd1, 1'b0, 1'b1);
    press("clear", 4'hA, 1'b0, 1'b0);
    chk_state("cleared", 16'h0000, 3'd0, 1'b0, 1'b0);

    // Rejected keys in IDLE
    press("enter idle", 4'hE, 1'b1, 1'b0);
    press("back idle", 4'hB, 1'b1, 1'b0);
    chk_state("idle kept", 16'h0000, 3'd0, 1'b0, 1'b0);

    // Overflow: 9,8,7,6,5
    press("d9", 4'h9, 1'b0, 1'b0);
    press("d8", 4'h8, 1'b0, 1'b0);
    press("d7", 4'h7, 1'b0, 1'b0);
    press("d6", 4'h6, 1'b0, 1'b0);
    chk_state("full", 16'h9876, 3'd4, 1'b1, 1'b1);
    press("d5 over", 4'h5, 1'b1, 1'b0);
    chk_state("full kept", 16'h9876, 3'd4, 1'b1, 1'b1);
    press("code C", 4'hC, 1'b1, 1'b0);
    chk_state("unassigned", 16'h9876, 3'd4, 1'b1, 1'b1);
    press("clear2", 4'hA, 1'b0, 1'b0);

    // Backspace: 4,2,BACK,BACK,BACK
    press("d4", 4'h4, 1'b0, 1'b0);
    press("d2b", 4'h2, 1'b0, 1'b0);
    chk_state("42", 16'h0042, 3'd2, 1'b0, 1'b1);
    press("back1", 4'hB, 1'b0, 1'b0);
    chk_state("4", 16'h0004, 3'd1, 1'b0, 1'b1);
    press("back2", 4'hB, 1'b0, 1'b0);
    chk_state("empty", 16'h0000, 3'd0, 1'b0, 1'b0);
    press("back3", 4'hB, 1'b1, 1'b0);
    chk_state("empty kept", 16'h0000, 3'd0, 1'b0, 1'b0);

    // Held key gives one event
    @(negedge clkot);
    key_valid = 1'b1;
    key_code  = 4'h5;
    for (int i = 0; i < 20; i++) begin
      @(posedge clkot);
      #1;
      if (i == 0) chk("hold err first", 32'(key_err), 32'(0));
      else chk("hold err", 32'(key_err), 32'(0));
    end
    chk_state("held 5", 16'h0005, 3'd1, 1'b0, 1'b1);
    @(negedge clkot);
    key_valid = 1'b0;
    @(posedge clkot);
    press("clear3", 4'hA, 1'b0, 1'b0);

    // Rejections in DONE
    press("d1b", 4'h1, 1'b0, 1'b0);
    press("enter2", 4'hE, 1'b0, 1'b1);
    press("back done", 4'hB, 1'b1, 1'b0);
    press("enter done", 4'hE, 1'b1, 1'b0);
    chk_state("done kept", 16'h0001, 3'd1, 1'b0, 1'b0);

    // Reset mid-entry abandons it
    press("d2c", 4'h2, 1'b0, 1'b0);
    chk_state("mid entry", 16'h0002, 3'd1, 1'b0, 1'b1);
    @(negedge clkot);
    rst_n = 1'b0;
    #1;
    chk_state("async rst", 16'h0000, 3'd0, 1'b0, 1'b0);
    @(posedge clkot);
    #1;
    chk("rst no done", 32'(entry_done), 32'(0));

    // Key held across reset release is ignored
    key_valid = 1'b1;
    key_code  = 4'h3;
    @(negedge clkot);
    rst_n = 1'b1;
    repeat (3) @(posedge clkot);
    #1;
    chk_state("held thru rst", 16'h0000, 3'd0, 1'b0, 1'b0);
    chk("held thru rst err", 32'(key_err), 32'(0));
    @(negedge clkot);
    key_valid = 1'b0;
    @(posedge clkot);
    press("d3 after rst", 4'h3, 1'b0, 1'b0);
    chk_state("after rst 3", 16'h0003, 3'd1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
